sd_req_arbiter: RTL and testbench

- Shares the single HPS virtual-disk sector channel between NREQ disk controllers (FDD0, FDD1, HDD).
- Each requester raises a level read or write request with an LBA. The arbiter grants requesters one at a time in round-robin order.
- For the granted requester it drives the per-VD sd_rd/sd_wr strobe and sd_lba, then tracks the sd_ack transfer window. During that window it steers sector-buffer traffic to and from the granted requester only.
- Sits between the disk-emulation core and the HPS I/O block, in the clk_sys domain.

---
 rtl/sd_req_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_sd_req_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_req_arbiter.sv
// ---------------------------------------------------------------------------
// sd_req_arbiter
//   Shares the single HPS virtual-disk sector channel between NREQ disk
//   controllers (e.g. FDD0, FDD1, HDD). Level read/write requests are granted
//   one at a time in round-robin order. For the granted requester the block
//   issues the per-VD sd_rd/sd_wr strobe with the latched LBA, waits for
//   sd_ack, and steers sector-buffer traffic to/from that requester only
//   while the transfer window is open. A watchdog aborts a command that never
//   sees an ack.
//
// Ports
//   clk_sys      in   system clock
//   reset        in   asynchronous, active-high reset
//   req_rd       in   [NREQ]     per-requester read request (level)
//   req_wr       in   [NREQ]     per-requester write request (level)
//   req_lba      in   [32*NREQ]  per-requester LBA, slice i = [32i+31:32i]
//   req_buff_din in   [8*NREQ]   per-requester write-data byte
//   req_done     out  [NREQ]     one-cycle completion pulse
//   req_err      out  [NREQ]     one-cycle timeout pulse
//   req_buff_wr  out  [NREQ]     sd_buff_wr gated to the granted requester
//   sd_lba       out  [32]       LBA to HPS
//   sd_rd        out  [NREQ]     read strobe, one-hot or zero
//   sd_wr        out  [NREQ]     write strobe, one-hot or zero
//   sd_ack       in   [NREQ]     per-VD ack from HPS
//   sd_buff_wr   in   1          buffer write strobe from HPS
//   sd_buff_din  out  [8]        write byte of granted requester, 0 when idle
//   busy         out  1          high whenever a command is in flight
// ---------------------------------------------------------------------------
module sd_req_arbiter #(
  parameter int NREQ = 3,
  parameter int TO_W = 24
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_rd,
  input  logic [NREQ-1:0]      req_wr,
  input  logic [32*NREQ-1:0]   req_lba,
  input  logic [8*NREQ-1:0]    req_buff_din,
  output logic [NREQ-1:0]      req_done,
  output logic [NREQ-1:0]      req_err,
  output logic [NREQ-1:0]      req_buff_wr,
  output logic [31:0]          sd_lba,
  output logic [NREQ-1:0]      sd_rd,
  output logic [NREQ-1:0]      sd_wr,
  input  logic [NREQ-1:0]      sd_ack,
  input  logic                 sd_buff_wr,
  output logic [7:0]           sd_buff_din,
  output logic                 busy
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACK,
    S_XFER,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [GW-1:0]     r_rr;
  logic [GW-1:0]     r_g;
  logic              r_is_rd;
  logic [31:0]       r_sd_lba;
  logic [NREQ-1:0]   r_sd_rd;
  logic [NREQ-1:0]   r_sd_wr;
  logic [NREQ-1:0]   r_req_done;
  logic [NREQ-1:0]   r_req_err;
  logic              r_busy;
  logic [TO_W-1:0]   r_wd;

  logic [NREQ-1:0]   w_pend;
  logic              w_sel_vld;
  logic [GW-1:0]     w_sel_idx;
  logic [GW-1:0]     w_cand;
  logic [31:0]       w_sel_lba;
  logic [NREQ-1:0]   w_g_oh;
  logic [TO_W-1:0]   w_wd_inc;

  assign w_pend    = req_rd | req_wr;
  assign w_sel_lba = req_lba[int'(w_sel_idx)*32 +: 32];
  assign w_g_oh    = NREQ'(1) << r_g;
  assign w_wd_inc  = r_wd + 1'b1;

  // Round-robin pick: first pending index at or after r_rr, wrapping.
  // NOTE: every combinational output gets a default before any condition so
  // no path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    w_sel_vld = 1'b0;
    w_sel_idx = '0;
    w_cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_cand = GW'((int'(r_rr) + k) % NREQ);
      if (!w_sel_vld && w_pend[w_cand]) begin
        w_sel_vld = 1'b1;
        w_sel_idx = w_cand;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every register in
  // this block samples pre-edge values, independent of statement order.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_rr       <= '0;
      r_g        <= '0;
      r_is_rd    <= 1'b0;
      r_sd_lba   <= '0;
      r_sd_rd    <= '0;
      r_sd_wr    <= '0;
      r_req_done <= '0;
      r_req_err  <= '0;
      r_busy     <= 1'b0;
      r_wd       <= '0;
    end else begin
      // Completion/error outputs are single-cycle pulses.
      r_req_done <= '0;
      r_req_err  <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_sel_vld) begin
            r_g      <= w_sel_idx;
            // Read wins when both are set; the write stays pending.
            r_is_rd  <= req_rd[w_sel_idx];
            r_sd_lba <= w_sel_lba;
            r_busy   <= 1'b1;
            r_state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_wd <= '0;
          if (r_is_rd) r_sd_rd <= w_g_oh;
          else         r_sd_wr <= w_g_oh;
          r_state <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          r_wd <= w_wd_inc;
          if (sd_ack[r_g]) begin
            r_sd_rd <= '0;
            r_sd_wr <= '0;
            r_state <= S_XFER;
          end else if (&w_wd_inc) begin
            // Strobe has been up for 2^TO_W-1 cycles with no ack: abort.
            r_sd_rd   <= '0;
            r_sd_wr   <= '0;
            r_req_err <= w_g_oh;
            r_state   <= S_DONE;
          end
        end
        S_XFER: begin
          // Entered with ack high, so a low ack here is its falling edge.
          if (!sd_ack[r_g]) begin
            r_req_done <= w_g_oh;
            r_state    <= S_DONE;
          end
        end
        S_DONE: begin
          r_rr    <= (r_g == GW'(NREQ-1)) ? '0 : r_g + 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Sector-buffer steering to/from the granted requester only.
  always_comb begin
    sd_buff_din = '0;
    req_buff_wr = '0;
    if (r_state == S_WAIT_ACK || r_state == S_XFER)
      sd_buff_din = req_buff_din[int'(r_g)*8 +: 8];
    if (r_state == S_XFER && sd_buff_wr)
      req_buff_wr = w_g_oh;
  end

  assign sd_lba   = r_sd_lba;
  assign sd_rd    = r_sd_rd;
  assign sd_wr    = r_sd_wr;
  assign req_done = r_req_done;
  assign req_err  = r_req_err;
  assign busy     = r_busy;

endmodule

// File: tb/tb_sd_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sd_req_arbiter
//   Directed stimulus for sd_req_arbiter (NREQ=3, TO_W=4). A command-level
//   reference model (grant pick, strobe lifetime, transfer window, pulses)
//   is compared against every DUT output on each falling clock edge, and
//   hand-computed literal expectations pin the key scenarios.
// ---------------------------------------------------------------------------
module tb_sd_req_arbiter;

  localparam int NREQ = 3;
  localparam int TO_W = 4;
  localparam int HOLD = (1 << TO_W) - 1;  // strobe cycles before timeout

  logic                clk_sys = 1'b0;
  logic                reset;
  logic [NREQ-1:0]     req_rd, req_wr;
  logic [32*NREQ-1:0]  req_lba;
  logic [8*NREQ-1:0]   req_buff_din;
  logic [NREQ-1:0]     req_done, req_err, req_buff_wr;
  logic [31:0]         sd_lba;
  logic [NREQ-1:0]     sd_rd, sd_wr, sd_ack;
  logic                sd_buff_wr;
  logic [7:0]          sd_buff_din;
  logic                busy;

  always #5 clk_sys = ~clk_sys;

  sd_req_arbiter #(.NREQ(NREQ), .TO_W(TO_W)) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .req_rd       (req_rd),
    .req_wr       (req_wr),
    .req_lba      (req_lba),
    .req_buff_din (req_buff_din),
    .req_done     (req_done),
    .req_err      (req_err),
    .req_buff_wr  (req_buff_wr),
    .sd_lba       (sd_lba),
    .sd_rd        (sd_rd),
    .sd_wr        (sd_wr),
    .sd_ack       (sd_ack),
    .sd_buff_wr   (sd_buff_wr),
    .sd_buff_din  (sd_buff_din),
    .busy         (busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [NREQ-1:0] oh(input int i);
    oh = '0;
    oh[i] = 1'b1;
  endfunction

  // First pending index at or after rr, wrapping; -1 if none.
  function automatic int pick(input logic [NREQ-1:0] pend, input int rr);
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (rr + k) % NREQ;
      if (pend[idx]) return idx;
    end
    return -1;
  endfunction

  // ---------------- reference model (command timeline) ----------------
  bit              m_active, m_issued, m_strobe, m_xfer, m_closing, m_rd;
  int              m_g, m_rr, m_hold;
  logic [31:0]     m_lba;
  logic [NREQ-1:0] m_done, m_err;

  always @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      m_active  <= 0; m_issued <= 0; m_strobe <= 0; m_xfer <= 0;
      m_closing <= 0; m_rd <= 0; m_g <= 0; m_rr <= 0; m_hold <= 0;
      m_lba <= '0; m_done <= '0; m_err <= '0;
    end else if (m_closing) begin
      // one cycle after completion/abort: back to idle, rotate pointer
      m_closing <= 0;
      m_active  <= 0;
      m_rr      <= (m_g + 1) % NREQ;
      m_done    <= '0;
      m_err     <= '0;
    end else if (!m_active) begin
      if ((req_rd | req_wr) != '0) begin
        m_g      <= pick(req_rd | req_wr, m_rr);
        m_rd     <= req_rd[pick(req_rd | req_wr, m_rr)];
        m_lba    <= req_lba[32*pick(req_rd | req_wr, m_rr) +: 32];
        m_active <= 1; m_issued <= 0; m_strobe <= 0; m_xfer <= 0;
      end
    end else if (!m_issued) begin
      m_issued <= 1;
      m_strobe <= 1;
      m_hold   <= 0;
    end else if (m_strobe) begin
      if (sd_ack[m_g]) begin
        m_strobe <= 0;
        m_xfer   <= 1;
      end else if (m_hold + 1 == HOLD) begin
        m_strobe  <= 0;
        m_err     <= oh(m_g);
        m_closing <= 1;
      end else begin
        m_hold <= m_hold + 1;
      end
    end else if (m_xfer) begin
      if (!sd_ack[m_g]) begin
        m_xfer    <= 0;
        m_done    <= oh(m_g);
        m_closing <= 1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk_sys) begin
    check("cyc_sd_rd",   sd_rd,    (m_strobe && m_rd)  ? oh(m_g) : '0);
    check("cyc_sd_wr",   sd_wr,    (m_strobe && !m_rd) ? oh(m_g) : '0);
    check("cyc_sd_lba",  sd_lba,   m_lba);
    check("cyc_busy",    busy,     m_active);
    check("cyc_done",    req_done, m_done);
    check("cyc_err",     req_err,  m_err);
    check("cyc_buff_din", sd_buff_din, (m_strobe || m_xfer) ? req_buff_din[8*m_g +: 8] : 8'h00);
    check("cyc_buff_wr", req_buff_wr, (m_xfer && sd_buff_wr) ? oh(m_g) : '0);
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk_sys);
      #2;
    end
  endtask

  task automatic wait_strobe(input string name);
    int n;
    n = 0;
    while ((sd_rd | sd_wr) == '0 && n < 20) begin
      step();
      n++;
    end
    if ((sd_rd | sd_wr) == '0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: no strobe seen after %0d cycles, required within 20", name, n);
    end
  endtask

  // One-cycle ack pulse, ends in the DONE cycle with req_done visible.
  task automatic serve(input string name, input int e);
    sd_ack[e] = 1'b1;
    step();
    sd_ack[e] = 1'b0;
    step();
    check(name, req_done, oh(e));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  int order[4] = '{0, 1, 2, 0};
  int cnt;

  initial begin
    reset = 1'b1;
    req_rd = '0; req_wr = '0; req_lba = '0; req_buff_din = '0;
    sd_ack = '0; sd_buff_wr = 1'b0;
    step(3);
    reset = 1'b0;
    check("rst_busy",   busy,  1'b0);
    check("rst_sd_rd",  sd_rd, 3'b000);
    check("rst_sd_lba", sd_lba, 32'h0);
    check("rst_done",   req_done, 3'b000);
    step(2);

    // ---- single read on requester 1, withdrawn after grant ----
    req_lba[32*1 +: 32] = 32'h0000_0123;
    req_rd[1] = 1'b1;
    step();
    check("rd_issue_no_strobe", sd_rd, 3'b000);
    check("rd_issue_busy", busy, 1'b1);
    step();
    check("rd_strobe_2cyc", sd_rd, 3'b010);
    check("rd_lba", sd_lba, 32'h123);
    req_rd[1] = 1'b0;
    req_lba[32*1 +: 32] = 32'hDEAD_BEEF;
    step(3);
    check("rd_strobe_held", sd_rd, 3'b010);
    check("rd_lba_held", sd_lba, 32'h123);
    sd_ack[1] = 1'b1;
    step();
    check("rd_strobe_drop", sd_rd, 3'b000);
    for (int i = 0; i < 512; i++) begin
      sd_buff_wr = 1'b1;
      #1;
      if (i < 2 || i == 511) check("rd_buff_wr_steer", req_buff_wr, 3'b010);
      step();
      sd_buff_wr = 1'b0;
      step();
    end
    sd_ack[1] = 1'b0;
    step();
    check("rd_done_pulse", req_done, 3'b010);
    check("rd_done_busy", busy, 1'b1);
    step();
    check("rd_done_clear", req_done, 3'b000);
    check("rd_idle_busy", busy, 1'b0);

    // ---- round robin from rr=0 ----
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    req_lba = {32'h0000_1002, 32'h0000_1001, 32'h0000_1000};
    req_rd  = 3'b111;
    for (int i = 0; i < 4; i++) begin
      wait_strobe("rr_wait");
      check("rr_grant", sd_rd, oh(order[i]));
      check("rr_lba", sd_lba, 32'h0000_1000 + 32'(order[i]));
      serve("rr_done", order[i]);
      req_rd[order[i]] = 1'b0;
      step();
      if (i < 3) req_rd[order[i]] = 1'b1;
      else       req_rd = '0;
    end
    step(2);

    // ---- write data steering on requester 2 ----
    req_buff_din[8*2 +: 8] = 8'hA5;
    req_buff_din[8*0 +: 8] = 8'h3C;
    req_wr[2] = 1'b1;
    wait_strobe("wr_wait");
    check("wr_strobe", sd_wr, 3'b100);
    check("wr_no_rd", sd_rd, 3'b000);
    check("wr_din_wait", sd_buff_din, 8'hA5);
    sd_buff_wr = 1'b1;
    #1;
    check("wr_no_buff_wr_in_wait", req_buff_wr, 3'b000);
    sd_buff_wr = 1'b0;
    sd_ack[2] = 1'b1;
    step();
    sd_buff_wr = 1'b1;
    #1;
    check("wr_buff_wr_steer", req_buff_wr, 3'b100);
    check("wr_din_xfer", sd_buff_din, 8'hA5);
    step();
    sd_buff_wr = 1'b0;
    sd_ack[2] = 1'b0;
    step();
    check("wr_done", req_done, 3'b100);
    check("wr_din_done", sd_buff_din, 8'h00);
    req_wr[2] = 1'b0;
    step();
    check("wr_din_idle", sd_buff_din, 8'h00);

    // ---- rd and wr both set on requester 0: read first ----
    req_rd[0] = 1'b1;
    req_wr[0] = 1'b1;
    wait_strobe("rw_wait1");
    check("rw_first_rd", sd_rd, 3'b001);
    check("rw_first_no_wr", sd_wr, 3'b000);
    serve("rw_done1", 0);
    req_rd[0] = 1'b0;
    wait_strobe("rw_wait2");
    check("rw_second_wr", sd_wr, 3'b001);
    check("rw_second_no_rd", sd_rd, 3'b000);
    serve("rw_done2", 0);
    req_wr[0] = 1'b0;
    step(2);

    // ---- timeout on requester 0, foreign ack ignored ----
    req_rd[0] = 1'b1;
    wait_strobe("to_wait");
    req_wr[1] = 1'b1;
    sd_ack[2] = 1'b1;
    cnt = 0;
    while (sd_rd == 3'b001 && cnt < 40) begin
      cnt++;
      step();
    end
    check("to_hold_cycles", cnt, 15);
    check("to_err", req_err, 3'b001);
    check("to_no_done", req_done, 3'b000);
    check("to_strobe_off", sd_rd, 3'b000);
    req_rd[0] = 1'b0;
    sd_ack[2] = 1'b0;
    step();
    check("to_err_clear", req_err, 3'b000);
    wait_strobe("to_next_wait");
    check("to_next_served", sd_wr, 3'b010);
    serve("to_next_done", 1);
    req_wr[1] = 1'b0;
    step(2);

    // ---- reset during XFER ----
    req_rd[1] = 1'b1;
    wait_strobe("rx_wait");
    check("rx_strobe", sd_rd, 3'b010);
    sd_ack[1] = 1'b1;
    step();
    sd_buff_wr = 1'b1;
    #1;
    check("rx_buff_wr_pre", req_buff_wr, 3'b010);
    reset = 1'b1;
    #1;
    check("rx_async_sd_rd", sd_rd, 3'b000);
    check("rx_async_sd_wr", sd_wr, 3'b000);
    check("rx_async_buff_wr", req_buff_wr, 3'b000);
    check("rx_async_busy", busy, 1'b0);
    check("rx_async_lba", sd_lba, 32'h0);
    req_rd = '0; sd_ack = '0; sd_buff_wr = 1'b0;
    step(2);
    reset = 1'b0;
    step(2);
    check("rx_idle_busy", busy, 1'b0);
    check("rx_no_done", req_done, 3'b000);
    req_rd = 3'b110;
    step(2);
    check("rx_rr_zero", sd_rd, 3'b010);
    serve("rx_done", 1);
    req_rd = '0;
    step(3);
    check("rx_final_idle", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
